// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback FIFOs.
// Optional hazard-lookup ports enabled by defining REGFILE_WB_HAZARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_dest,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_dest,
  input  logic [DATA_W-1:0] req1_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              busy
`ifdef REGFILE_WB_HAZARD_EN
  ,
  input  logic [ADDR_W-1:0] hz_addr_1,
  input  logic [ADDR_W-1:0] hz_addr_2,
  output logic              hz_1,
  output logic              hz_2
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {GNT_ALU = 1'b0, GNT_LOAD = 1'b1} grant_t;

  logic [ADDR_W-1:0] dest_mem [2][DEPTH];
  logic [DATA_W-1:0] data_mem [2][DEPTH];
  logic [PTR_W-1:0]  rd_ptr   [2];
  logic [PTR_W-1:0]  wr_ptr   [2];
  logic [CNT_W-1:0]  count    [2];

  logic              in_valid [2];
  logic [ADDR_W-1:0] in_dest  [2];
  logic [DATA_W-1:0] in_data  [2];
  logic              ready    [2];
  logic              push     [2];
  logic              pop      [2];

  grant_t            last_grant;
  grant_t            grant;
  logic              grant_valid;
  logic [ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    in_valid[0] = req0_valid;
    in_dest[0]  = req0_dest;
    in_data[0]  = req0_data;
    in_valid[1] = req1_valid;
    in_dest[1]  = req1_dest;
    in_data[1]  = req1_data;
    for (int unsigned k = 0; k < 2; k++) begin
      ready[k] = (count[k] != CNT_W'(DEPTH));
      // dest 0 completes the handshake but is dropped instead of queued
      push[k]  = in_valid[k] && ready[k] && (in_dest[k] != '0);
    end
    grant_valid = (count[0] != '0) || (count[1] != '0);
    if ((count[0] != '0) && (count[1] != '0))
      grant = (last_grant == GNT_ALU) ? GNT_LOAD : GNT_ALU;
    else
      grant = (count[1] != '0) ? GNT_LOAD : GNT_ALU;
    pop[0] = grant_valid && (grant == GNT_ALU);
    pop[1] = grant_valid && (grant == GNT_LOAD);
    if (grant == GNT_LOAD) begin
      head_dest = dest_mem[1][rd_ptr[1]];
      head_data = data_mem[1][rd_ptr[1]];
    end else begin
      head_dest = dest_mem[0][rd_ptr[0]];
      head_data = data_mem[0][rd_ptr[0]];
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign busy       = (count[0] != '0) || (count[1] != '0) || reg_write_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < 2; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        count[k]  <= '0;
      end
      last_grant     <= GNT_LOAD;
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        if (push[k] && !pop[k])      count[k] <= count[k] + CNT_W'(1);
        else if (!push[k] && pop[k]) count[k] <= count[k] - CNT_W'(1);
      end
      reg_write_en <= grant_valid;
      if (grant_valid) begin
        reg_write_dest <= head_dest;
        reg_write_data <= head_data;
        last_grant     <= grant;
      end
    end
  end

  // Storage needs no reset: only slots counted by count[] are ever read.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 2; k++) begin
      if (push[k]) begin
        dest_mem[k][wr_ptr[k]] <= in_dest[k];
        data_mem[k][wr_ptr[k]] <= in_data[k];
      end
    end
  end

`ifdef REGFILE_WB_HAZARD_EN
  always_comb begin
    hz_1 = reg_write_en && (reg_write_dest == hz_addr_1);
    hz_2 = reg_write_en && (reg_write_dest == hz_addr_2);
    for (int unsigned k = 0; k < 2; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) < count[k]) begin
          if (dest_mem[k][rd_ptr[k] + PTR_W'(i)] == hz_addr_1) hz_1 = 1'b1;
          if (dest_mem[k][rd_ptr[k] + PTR_W'(i)] == hz_addr_2) hz_2 = 1'b1;
        end
      end
    end
    if (hz_addr_1 == '0) hz_1 = 1'b0;
    if (hz_addr_2 == '0) hz_2 = 1'b0;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_dest, req1_dest;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic              busy;
`ifdef REGFILE_WB_HAZARD_EN
  logic [ADDR_W-1:0] hz_addr_1, hz_addr_2;
  logic              hz_1, hz_2;
`endif

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dest(req0_dest), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dest(req1_dest), .req1_data(req1_data),
    .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
    .busy(busy)
`ifdef REGFILE_WB_HAZARD_EN
    , .hz_addr_1(hz_addr_1), .hz_addr_2(hz_addr_2), .hz_1(hz_1), .hz_2(hz_2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] d;
    logic [DATA_W-1:0] v;
  } ent_t;

  ent_t              q0[$];
  ent_t              q1[$];
  int                m_last;
  logic              exp_en;
  logic [ADDR_W-1:0] exp_dest;
  logic [DATA_W-1:0] exp_data;
  int                n_load_wr;
  bit                last_acc1;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_last   = 1;
    exp_en   = 1'b0;
    exp_dest = '0;
    exp_data = '0;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
    req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
  endtask

  function automatic bit in_q(input logic [ADDR_W-1:0] a);
    foreach (q0[i]) if (q0[i].d == a) return 1'b1;
    foreach (q1[i]) if (q1[i].d == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    check("en",     32'(reg_write_en),   32'(exp_en));
    check("dest",   32'(reg_write_dest), 32'(exp_dest));
    check("data",   reg_write_data,      exp_data);
    check("busy",   32'(busy),   32'((q0.size() > 0) || (q1.size() > 0) || exp_en));
    check("ready0", 32'(req0_ready), 32'(q0.size() < DEPTH));
    check("ready1", 32'(req1_ready), 32'(q1.size() < DEPTH));
`ifdef REGFILE_WB_HAZARD_EN
    check("hz_1", 32'(hz_1), 32'((hz_addr_1 != 0) && (in_q(hz_addr_1) || (exp_en && exp_dest == hz_addr_1))));
    check("hz_2", 32'(hz_2), 32'((hz_addr_2 != 0) && (in_q(hz_addr_2) || (exp_en && exp_dest == hz_addr_2))));
`endif
  endtask

  // One clock: decide grant/acceptance from the pre-edge model state, then advance and compare.
  task automatic step();
    bit   acc0, acc1;
    int   g;
    ent_t e;
    acc0 = reset && req0_valid && (q0.size() < DEPTH);
    acc1 = reset && req1_valid && (q1.size() < DEPTH);
    if (!reset)                          g = -1;
    else if (q0.size() > 0 && q1.size() > 0) g = (m_last == 1) ? 0 : 1;
    else if (q0.size() > 0)              g = 0;
    else if (q1.size() > 0)              g = 1;
    else                                 g = -1;
    @(posedge clk);
    #1;
    if (g == 0) begin
      e = q0.pop_front();
      exp_en = 1'b1; exp_dest = e.d; exp_data = e.v; m_last = 0;
    end else if (g == 1) begin
      e = q1.pop_front();
      exp_en = 1'b1; exp_dest = e.d; exp_data = e.v; m_last = 1;
      n_load_wr++;
    end else begin
      exp_en = 1'b0;
    end
    if (acc0 && req0_dest != 0) q0.push_back('{req0_dest, req0_data});
    if (acc1 && req1_dest != 0) q1.push_back('{req1_dest, req1_data});
    last_acc1 = acc1;
    check_outputs();
  endtask

  initial begin
    int load_base;
    int sent;
    logic [DATA_W-1:0] load_vals [3];
    clear_inputs();
`ifdef REGFILE_WB_HAZARD_EN
    hz_addr_1 = '0;
    hz_addr_2 = '0;
`endif
    n_load_wr = 0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("rst_en", 32'(reg_write_en), 32'd0);
    reset = 1'b1;
    step();

    // Single ALU write: visible for exactly one cycle after the enqueue edge.
    req0_valid = 1'b1; req0_dest = 5'd5; req0_data = 32'h1234;
    step();
    clear_inputs();
    step();
    check("single_en",   32'(reg_write_en),   32'd1);
    check("single_dest", 32'(reg_write_dest), 32'd5);
    check("single_data", reg_write_data,      32'h1234);
    step();
    check("single_off",  32'(reg_write_en),   32'd0);

    // Tie after reset: ALU first, then load; repeated pair keeps the same order.
    reset = 1'b0; model_reset(); #2; reset = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      req0_valid = 1'b1; req0_dest = 5'd3; req0_data = 32'hA0 + rep;
      req1_valid = 1'b1; req1_dest = 5'd4; req1_data = 32'hB0 + rep;
      step();
      clear_inputs();
      step();
      check("tie_first",  32'(reg_write_dest), 32'd3);
      step();
      check("tie_second", 32'(reg_write_dest), 32'd4);
    end
    step();

    // Backpressure: three loads while ALU saturates; none may be lost.
    load_base = n_load_wr;
    sent = 0;
    for (int i = 0; i < 3; i++) load_vals[i] = $urandom;
    for (int cyc = 0; cyc < 40; cyc++) begin
      req0_valid = 1'b1;
      req0_dest  = 5'($urandom_range(1, 31));
      req0_data  = $urandom;
      req1_valid = (sent < 3);
      req1_dest  = 5'(20 + sent);
      req1_data  = (sent < 3) ? load_vals[sent] : '0;
      step();
      if (last_acc1) sent++;
      if (sent == 3 && cyc > 10) break;
    end
    clear_inputs();
    repeat (8) step();
    check("bp_loads", 32'(n_load_wr - load_base), 32'd3);

    // dest 0 is accepted and silently dropped.
    req0_valid = 1'b1; req0_dest = '0; req0_data = 32'hDEAD;
    check("d0_ready", 32'(req0_ready), 32'd1);
    step();
    clear_inputs();
    step();
    check("d0_en",   32'(reg_write_en), 32'd0);
    check("d0_busy", 32'(busy),         32'd0);

    // Async reset with two entries queued discards them.
    req0_valid = 1'b1; req0_dest = 5'd7; req0_data = 32'h77;
    req1_valid = 1'b1; req1_dest = 5'd8; req1_data = 32'h88;
    step();
    clear_inputs();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    reset = 1'b1;
    step();
    step();
    check("rst_noq_en", 32'(reg_write_en), 32'd0);

`ifdef REGFILE_WB_HAZARD_EN
    hz_addr_1 = 5'd17;
    hz_addr_2 = '0;
    req1_valid = 1'b1; req1_dest = 5'd17; req1_data = 32'h1717;
    step();
    check("hz_queued", 32'(hz_1), 32'd1);
    clear_inputs();
    step();
    check("hz_writing", 32'(hz_1), 32'd1);
    check("hz_zero",    32'(hz_2), 32'd0);
    step();
    check("hz_done", 32'(hz_1), 32'd0);
`endif

    // Random traffic, small dest range so collisions and dest 0 occur.
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req0_dest  = 5'($urandom_range(0, 7));
      req0_data  = $urandom;
      req1_valid = 1'($urandom_range(0, 1));
      req1_dest  = 5'($urandom_range(0, 7));
      req1_data  = $urandom;
`ifdef REGFILE_WB_HAZARD_EN
      hz_addr_1 = 5'($urandom_range(0, 7));
      hz_addr_2 = 5'($urandom_range(0, 7));
`endif
      step();
    end
    clear_inputs();
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
